// File: rtl/video_pattern_gen.sv
// Video timing source with a binary foreground pattern (rectangles or checkerboard).
// Every output is a registered decode of the h/v counters, one cycle behind them.
module video_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK = 150,
   parameter int V_ACTIVE = 480,
   parameter int V_BLANK = 20,
   parameter int NUM_RECTS = 2,
   parameter int RECT_W = 180,
   parameter int RECT_H = 94,
   parameter logic [11*NUM_RECTS-1:0] RECT_X0 = {11'd450, 11'd21},
   parameter logic [11*NUM_RECTS-1:0] RECT_Y0 = {11'd300, 11'd6},
   parameter logic [3:0] VEL = 4'd2,
   parameter int CHECK_LOG2 = 5
) (
   input  logic        app_clk,
   input  logic        app_rst,
   input  logic        en,
   input  logic [1:0]  mode,
   output logic [10:0] vid_hpos,
   output logic [10:0] vid_vpos,
   output logic        vid_active_pix,
   output logic        vid_preload_line,
   output logic        frame_start,
   output logic        foregnd_px
);

   localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_BLANK - 1);
   localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_BLANK - 1);
   localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
   localparam logic [12:0] X_MAX = 13'(H_ACTIVE - RECT_W);
   localparam logic [12:0] Y_MAX = 13'(V_ACTIVE - RECT_H);
   localparam logic [11:0] RW = 12'(RECT_W);
   localparam logic [11:0] RH = 12'(RECT_H);
   localparam logic [4:0] VEL_POS = {1'b0, VEL};
   localparam logic [4:0] VEL_NEG = 5'd0 - {1'b0, VEL};

   logic [10:0] hcnt_q, hcnt_d;
   logic [10:0] vcnt_q, vcnt_d;
   logic [10:0] nextLine;
   logic        lineEnd;
   logic        frameEnd;

   logic [10:0] x_q [NUM_RECTS];
   logic [10:0] x_d [NUM_RECTS];
   logic [10:0] y_q [NUM_RECTS];
   logic [10:0] y_d [NUM_RECTS];
   logic [4:0]  vx_q [NUM_RECTS];
   logic [4:0]  vx_d [NUM_RECTS];
   logic [4:0]  vy_q [NUM_RECTS];
   logic [4:0]  vy_d [NUM_RECTS];

   logic        moveNow;
   logic [12:0] nx;
   logic [12:0] ny;

   logic        activeNow;
   logic [10:0] hposNow;
   logic        hit;
   logic        fgNow;

   always_comb begin
      lineEnd  = (hcnt_q == H_LAST);
      frameEnd = lineEnd && (vcnt_q == V_LAST);
      nextLine = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
      hcnt_d   = lineEnd ? 11'd0 : hcnt_q + 11'd1;
      vcnt_d   = lineEnd ? nextLine : vcnt_q;
   end

   // Bounce test uses a 13-bit sum so a step below zero shows up in the top bit.
   always_comb begin
      moveNow = en && (mode == 2'd2) && frameEnd;
      nx = '0;
      ny = '0;
      for (int i = 0; i < NUM_RECTS; i++) begin
         x_d[i]  = x_q[i];
         y_d[i]  = y_q[i];
         vx_d[i] = vx_q[i];
         vy_d[i] = vy_q[i];
         nx = {2'b00, x_q[i]} + {{8{vx_q[i][4]}}, vx_q[i]};
         ny = {2'b00, y_q[i]} + {{8{vy_q[i][4]}}, vy_q[i]};
         if (moveNow) begin
            if (!nx[12] && (nx <= X_MAX)) begin
               x_d[i] = nx[10:0];
            end else begin
               vx_d[i] = 5'd0 - vx_q[i];
            end
            if (!ny[12] && (ny <= Y_MAX)) begin
               y_d[i] = ny[10:0];
            end else begin
               vy_d[i] = 5'd0 - vy_q[i];
            end
         end
      end
   end

   always_comb begin
      activeNow = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hposNow   = (hcnt_q < H_ACT) ? hcnt_q : H_ACT - 11'd1;
      hit = 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
         if (({1'b0, x_q[i]} <= {1'b0, hcnt_q}) && ({1'b0, hcnt_q} < {1'b0, x_q[i]} + RW) &&
             ({1'b0, y_q[i]} <= {1'b0, vcnt_q}) && ({1'b0, vcnt_q} < {1'b0, y_q[i]} + RH)) begin
            hit = 1'b1;
         end
      end
      fgNow = 1'b0;
      case (mode)
         2'd1, 2'd2: fgNow = hit;
         2'd3:       fgNow = hcnt_q[CHECK_LOG2] ^ vcnt_q[CHECK_LOG2];
         default:    fgNow = 1'b0;
      endcase
      fgNow = fgNow && activeNow;
   end

   // With en low the counters and position outputs hold while the strobes drop to 0.
   always_ff @(posedge app_clk or posedge app_rst) begin
      if (app_rst) begin
         hcnt_q           <= '0;
         vcnt_q           <= '0;
         vid_hpos         <= '0;
         vid_vpos         <= '0;
         vid_active_pix   <= 1'b0;
         vid_preload_line <= 1'b0;
         frame_start      <= 1'b0;
         foregnd_px       <= 1'b0;
         for (int i = 0; i < NUM_RECTS; i++) begin
            x_q[i]  <= RECT_X0[11*i +: 11];
            y_q[i]  <= RECT_Y0[11*i +: 11];
            vx_q[i] <= (i % 2 == 0) ? VEL_POS : VEL_NEG;
            vy_q[i] <= VEL_POS;
         end
      end else begin
         for (int i = 0; i < NUM_RECTS; i++) begin
            x_q[i]  <= x_d[i];
            y_q[i]  <= y_d[i];
            vx_q[i] <= vx_d[i];
            vy_q[i] <= vy_d[i];
         end
         if (en) begin
            hcnt_q           <= hcnt_d;
            vcnt_q           <= vcnt_d;
            vid_hpos         <= hposNow;
            vid_vpos         <= vcnt_q;
            vid_active_pix   <= activeNow;
            vid_preload_line <= (hcnt_q == H_ACT) && (nextLine < V_ACT);
            frame_start      <= (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
            foregnd_px       <= fgNow;
         end else begin
            vid_active_pix   <= 1'b0;
            vid_preload_line <= 1'b0;
            frame_start      <= 1'b0;
            foregnd_px       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomised bench for video_pattern_gen: a frame-position model is compared
// against the DUT every cycle, plus hand-computed per-frame expectations.
module tb_video_pattern_gen;

   localparam int HA = 16;
   localparam int HB = 4;
   localparam int VA = 8;
   localparam int VB = 2;
   localparam int HT = HA + HB;
   localparam int VT = VA + VB;
   localparam int FP = HT * VT;
   localparam int RW = 4;
   localparam int RH = 2;
   localparam int CL = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [10:0] vid_hpos;
   logic [10:0] vid_vpos;
   logic        vid_active_pix;
   logic        vid_preload_line;
   logic        frame_start;
   logic        foregnd_px;

   video_pattern_gen #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
      .NUM_RECTS(1), .RECT_W(RW), .RECT_H(RH),
      .RECT_X0(11'd2), .RECT_Y0(11'd1), .VEL(4'd3), .CHECK_LOG2(CL)
   ) dut (
      .app_clk(clk),
      .app_rst(rst),
      .en(en),
      .mode(mode),
      .vid_hpos(vid_hpos),
      .vid_vpos(vid_vpos),
      .vid_active_pix(vid_active_pix),
      .vid_preload_line(vid_preload_line),
      .frame_start(frame_start),
      .foregnd_px(foregnd_px)
   );

   always #5 clk = ~clk;

   int   vectors = 0;
   int   miscompares = 0;
   int   failPrints = 0;
   logic checkOn = 1'b0;

   // Model: position within the frame as a single enabled-cycle index.
   int   pos, rx, ry, rvx, rvy;
   int   eHpos, eVpos;
   logic eAct, ePre, eFs, eFg;

   // Per-run statistics gathered from the DUT outputs.
   int cycleIdx, fsCount, firstFs, prevFs, fsSpacing, actCount, preCount, preMask;
   int fgCount, hMask, vMask, minH, minV, rowA, rowB;

   function automatic logic patternBit(input int m, input int h, input int v);
      if (m == 1 || m == 2)
         return (rx <= h) && (h < rx + RW) && (ry <= v) && (v < ry + RH);
      if (m == 3)
         return logic'(((h >> CL) & 1) ^ ((v >> CL) & 1));
      return 1'b0;
   endfunction

   task automatic modelReset();
      pos = 0; rx = 2; ry = 1; rvx = 3; rvy = 3;
      eHpos = 0; eVpos = 0;
      eAct = 1'b0; ePre = 1'b0; eFs = 1'b0; eFg = 1'b0;
   endtask

   task automatic modelStep();
      int hc, vc;
      if (!en) begin
         eAct = 1'b0; ePre = 1'b0; eFs = 1'b0; eFg = 1'b0;
         return;
      end
      hc = pos % HT;
      vc = pos / HT;
      eHpos = (hc < HA) ? hc : HA - 1;
      eVpos = vc;
      eAct  = (hc < HA) && (vc < VA);
      ePre  = (hc == HA) && (((vc + 1) % VT) < VA);
      eFs   = (pos == 0);
      eFg   = eAct && patternBit(int'(mode), hc, vc);
      if (mode == 2'd2 && pos == FP - 1) begin
         if (rx + rvx >= 0 && rx + rvx <= HA - RW) rx = rx + rvx; else rvx = -rvx;
         if (ry + rvy >= 0 && ry + rvy <= VA - RH) ry = ry + rvy; else rvy = -rvy;
      end
      pos = (pos + 1) % FP;
   endtask

   task automatic clearStats();
      cycleIdx = 0; fsCount = 0; firstFs = -1; prevFs = -1; fsSpacing = -1;
      actCount = 0; preCount = 0; preMask = 0;
      fgCount = 0; hMask = 0; vMask = 0; minH = 999; minV = 999; rowA = 0; rowB = 0;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   // Inputs change 2 time units after a rising edge; stats are sampled at the same point.
   task automatic applyStimulus(input logic e, input logic [1:0] m, input int n);
      en = e;
      mode = m;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         if (!rst) modelStep();
         #2;
         cycleIdx++;
         if (frame_start) begin
            fsCount++;
            if (firstFs < 0) firstFs = cycleIdx;
            if (prevFs >= 0) fsSpacing = cycleIdx - prevFs;
            prevFs = cycleIdx;
         end
         if (vid_active_pix) actCount++;
         if (vid_preload_line) begin
            preCount++;
            preMask |= 1 << vid_vpos;
         end
         if (foregnd_px) begin
            fgCount++;
            hMask |= 1 << vid_hpos;
            vMask |= 1 << vid_vpos;
            if (int'(vid_hpos) < minH) minH = int'(vid_hpos);
            if (int'(vid_vpos) < minV) minV = int'(vid_vpos);
         end
         if (vid_active_pix && vid_vpos == 11'd0) rowA[vid_hpos] = foregnd_px;
         if (vid_active_pix && vid_vpos == 11'd2) rowB[vid_hpos] = foregnd_px;
      end
   endtask

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (checkOn) begin
            vectors++;
            if (vid_hpos !== 11'(eHpos) || vid_vpos !== 11'(eVpos) || vid_active_pix !== eAct ||
                vid_preload_line !== ePre || frame_start !== eFs || foregnd_px !== eFg) begin
               miscompares++;
               if (failPrints < 20) begin
                  failPrints++;
                  $display("[TB] FAIL cycle t=%0t: got h=%0d v=%0d act=%b pre=%b fs=%b fg=%b, expected h=%0d v=%0d act=%b pre=%b fs=%b fg=%b",
                           $time, vid_hpos, vid_vpos, vid_active_pix, vid_preload_line, frame_start, foregnd_px,
                           eHpos, eVpos, eAct, ePre, eFs, eFg);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   xs [6] = '{2, 5, 8, 11, 11, 8};
      int   ys [6] = '{1, 4, 4, 1, 1, 4};
      int   heldV, holdErr, found;
      logic e;
      logic [1:0] m;
      int   n;

      modelReset();
      #1 rst = 1'b1;
      #2 checkOn = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset outputs", int'({vid_hpos, vid_vpos, vid_active_pix, vid_preload_line, frame_start, foregnd_px}), 0);
      rst = 1'b0;

      $display("[TB] timing, mode 0");
      clearStats();
      applyStimulus(1'b1, 2'd0, 2 * FP);
      checkOutput("first frame_start cycle", firstFs, 1);
      checkOutput("frame_start count", fsCount, 2);
      checkOutput("frame_start spacing", fsSpacing, 200);
      checkOutput("active pixels 2 frames", actCount, 256);
      checkOutput("preload count 2 frames", preCount, 16);
      checkOutput("preload line set", preMask, 'h27F);
      checkOutput("fg in mode 0", fgCount, 0);

      $display("[TB] static rectangle, mode 1");
      for (int f = 0; f < 2; f++) begin
         clearStats();
         applyStimulus(1'b1, 2'd1, FP);
         checkOutput("static fg count", fgCount, 8);
         checkOutput("static fg columns", hMask, 'h3C);
         checkOutput("static fg lines", vMask, 'h6);
      end

      $display("[TB] motion and bounce, mode 2");
      for (int f = 0; f < 6; f++) begin
         clearStats();
         applyStimulus(1'b1, 2'd2, FP);
         checkOutput("motion x", minH, xs[f]);
         checkOutput("motion y", minV, ys[f]);
      end

      clearStats();
      applyStimulus(1'b1, 2'd1, FP);
      checkOutput("frozen x", minH, 5);
      checkOutput("frozen y", minV, 4);
      checkOutput("frozen fg count", fgCount, 8);

      $display("[TB] checkerboard, mode 3");
      clearStats();
      applyStimulus(1'b1, 2'd3, FP);
      checkOutput("checker row v0", rowA, 'hCCCC);
      checkOutput("checker row v2", rowB, 'h3333);

      $display("[TB] freeze mid-line");
      found = 0;
      for (int k = 0; k < 400 && found == 0; k++) begin
         applyStimulus(1'b1, 2'd3, 1);
         if (vid_hpos == 11'd9 && vid_active_pix) found = 1;
      end
      checkOutput("wait for hpos 9", found, 1);
      heldV = int'(vid_vpos);
      holdErr = 0;
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b0, 2'd3, 1);
         if (vid_hpos != 11'd9 || int'(vid_vpos) != heldV || vid_active_pix || foregnd_px) holdErr++;
      end
      checkOutput("freeze hold", holdErr, 0);
      applyStimulus(1'b1, 2'd3, 1);
      checkOutput("resume hpos", int'(vid_hpos), 10);
      checkOutput("resume vpos", int'(vid_vpos), heldV);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 2'd2, 3 * FP);
      found = 0;
      for (int k = 0; k < 400 && found == 0; k++) begin
         applyStimulus(1'b1, 2'd2, 1);
         if (vid_vpos == 11'd5) found = 1;
      end
      checkOutput("wait for vpos 5", found, 1);
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("outputs on reset", int'({vid_hpos, vid_vpos, vid_active_pix, vid_preload_line, frame_start, foregnd_px}), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      clearStats();
      applyStimulus(1'b1, 2'd2, FP);
      checkOutput("post-reset frame_start", firstFs, 1);
      checkOutput("post-reset x", minH, 2);
      checkOutput("post-reset y", minV, 1);

      $display("[TB] randomised phase");
      for (int s = 0; s < 40; s++) begin
         m = 2'($urandom_range(0, 3));
         n = $urandom_range(1, 300);
         for (int k = 0; k < n; k++) begin
            e = ($urandom_range(0, 9) != 0);
            applyStimulus(e, m, 1);
         end
         if ($urandom_range(0, 15) == 0) begin
            rst = 1'b1;
            modelReset();
            @(posedge clk);
            #2 rst = 1'b0;
         end
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
